// File: rtl/fifo_bus_arbiter_if.sv
// Bundle of signals between the arbiter, the per-driver source FIFOs and the
// shared output bus.
//   pndng_i     per-FIFO non-empty flags
//   dato_i      per-FIFO head words, FIFO i at [i*width +: width]
//   pop_o       one-hot pop strobe back to the FIFOs
//   bus_dato_o  word offered on the shared bus
//   bus_id_o    index of the FIFO that supplied the word
//   bus_valid_o bus word valid
//   bus_ack_i   bus accepted the word
//   busy_o      arbiter not idle
//   err_o       one-cycle pulse when a word is dropped on ack timeout
// master: arbiter side.  slave: FIFO/bus side.
interface fifo_bus_arbiter_if #(
   parameter int drvrs = 4,
   parameter int width = 16
);
   localparam int id_w = $clog2(drvrs);

   logic [drvrs-1:0]       pndng_i;
   logic [drvrs*width-1:0] dato_i;
   logic [drvrs-1:0]       pop_o;
   logic [width-1:0]       bus_dato_o;
   logic [id_w-1:0]        bus_id_o;
   logic                   bus_valid_o;
   logic                   bus_ack_i;
   logic                   busy_o;
   logic                   err_o;

   modport master (
      input  pndng_i, dato_i, bus_ack_i,
      output pop_o, bus_dato_o, bus_id_o, bus_valid_o, busy_o, err_o
   );

   modport slave (
      output pndng_i, dato_i, bus_ack_i,
      input  pop_o, bus_dato_o, bus_id_o, bus_valid_o, busy_o, err_o
   );
endinterface

// File: rtl/fifo_bus_arbiter.sv
// Round-robin arbiter sharing one output bus between drvrs source FIFOs.
// Picks a pending FIFO starting from the rotating pointer, pops its head word,
// then offers the word and source id on the bus until acked or timed out.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_bus_arbiter_if.master (FIFO flags/data, pop, bus handshake,
//          busy and timeout error)
//
// state | meaning
// IDLE  | waiting for any pending FIFO; winner latched into grant
// POP   | pop granted FIFO and capture its head word (abort if it emptied)
// SEND  | word valid on the bus until ack or timeout
module fifo_bus_arbiter #(
   parameter int drvrs       = 4,
   parameter int width       = 16,
   parameter int ack_timeout = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_bus_arbiter_if.master  bus
);

   localparam int id_w  = $clog2(drvrs);
   // The counter holds the number of ack-less SEND cycles already completed,
   // so the timeout fires in the cycle where it equals ack_timeout-1.
   localparam int cnt_w = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
   localparam logic [cnt_w-1:0] to_last =
      cnt_w'((ack_timeout > 0) ? ack_timeout - 1 : 0);

   typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

   state_t            state_q, state_d;
   logic [id_w-1:0]   rr_q, rr_d;
   logic [id_w-1:0]   grant_q, grant_d;
   logic [id_w-1:0]   id_q, id_d;
   logic [width-1:0]  data_q, data_d;
   logic [cnt_w-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [id_w-1:0]   winner;
   logic [id_w-1:0]   next_ptr;
   logic [drvrs-1:0]  pop;

   // First pending bit at or above the pointer, wrapping modulo drvrs.
   always_comb begin
      logic found;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < drvrs; i++) begin
         if (!found && bus.pndng_i[(int'(rr_q) + i) % drvrs]) begin
            winner = id_w'((int'(rr_q) + i) % drvrs);
            found  = 1'b1;
         end
      end
   end

   assign next_ptr = (int'(grant_q) == drvrs - 1) ? '0 : grant_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         id_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      id_d    = id_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      pop     = '0;
      case (state_q)
         IDLE: begin
            if (|bus.pndng_i) begin
               grant_d = winner;
               state_d = POP;
            end
         end
         POP: begin
            if (bus.pndng_i[grant_q]) begin
               pop[grant_q] = 1'b1;
               data_d       = bus.dato_i[int'(grant_q)*width +: width];
               id_d         = grant_q;
               cnt_d        = '0;
               state_d      = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (bus.bus_ack_i) begin
               rr_d    = next_ptr;
               state_d = IDLE;
            end else if (ack_timeout != 0 && cnt_q == to_last) begin
               rr_d    = next_ptr;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.pop_o       = pop;
   assign bus.bus_valid_o = (state_q == SEND);
   assign bus.bus_dato_o  = (state_q == SEND) ? data_q : '0;
   assign bus.bus_id_o    = (state_q == SEND) ? id_q : '0;
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
module tb_fifo_bus_arbiter;
   localparam int D  = 4;
   localparam int W  = 16;
   localparam int T  = 16;
   localparam int IW = $clog2(D);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_bus_arbiter_if #(.drvrs(D), .width(W)) bus ();

   fifo_bus_arbiter #(.drvrs(D), .width(W), .ack_timeout(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int errors = 0;
   int checks = 0;

   // Observed DUT activity.
   int dut_pops  = 0;
   int dut_valid = 0;
   int dut_errs  = 0;
   int          deliv_id[$];
   logic [W-1:0] deliv_dat[$];

   // Transaction-level reference: phase 0 waiting, 1 popping, 2 offering.
   int           m_phase, m_ptr, m_grant, m_waits, m_id;
   logic [W-1:0] m_word;
   logic         m_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int ptr, input logic [D-1:0] p);
      for (int k = 0; k < D; k++)
         if (p[(ptr + k) % D]) return (ptr + k) % D;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_grant = 0; m_waits = 0; m_id = 0;
      m_word = '0; m_err = 1'b0;
   endtask

   // Per-cycle compare; inputs only change just after rising edges, so the
   // values seen here are the ones the next rising edge will sample.
   always @(negedge clk) begin
      logic [D-1:0]  e_pop;
      logic [W-1:0]  e_dat;
      logic [IW-1:0] e_id;
      logic          new_err;
      if (!rst_n) begin
         chk("rst_pop",   bus.pop_o, 0);
         chk("rst_valid", bus.bus_valid_o, 0);
         chk("rst_dato",  bus.bus_dato_o, 0);
         chk("rst_id",    bus.bus_id_o, 0);
         chk("rst_busy",  bus.busy_o, 0);
         chk("rst_err",   bus.err_o, 0);
         model_reset();
      end else begin
         e_pop = '0;
         if (m_phase == 1 && bus.pndng_i[m_grant]) e_pop[m_grant] = 1'b1;
         e_dat = (m_phase == 2) ? m_word : '0;
         e_id  = (m_phase == 2) ? IW'(m_id) : '0;
         chk("pop",   bus.pop_o, e_pop);
         chk("valid", bus.bus_valid_o, m_phase == 2);
         chk("dato",  bus.bus_dato_o, e_dat);
         chk("id",    bus.bus_id_o, e_id);
         chk("busy",  bus.busy_o, m_phase != 0);
         chk("err",   bus.err_o, m_err);

         if (bus.pop_o != 0) dut_pops++;
         if (bus.bus_valid_o) dut_valid++;
         if (bus.err_o) dut_errs++;
         if (bus.bus_valid_o && bus.bus_ack_i) begin
            deliv_id.push_back(int'(bus.bus_id_o));
            deliv_dat.push_back(bus.bus_dato_o);
         end

         new_err = 1'b0;
         case (m_phase)
            0: if (bus.pndng_i != 0) begin
                  m_grant = rr_pick(m_ptr, bus.pndng_i);
                  m_phase = 1;
               end
            1: if (bus.pndng_i[m_grant]) begin
                  m_word  = bus.dato_i[m_grant*W +: W];
                  m_id    = m_grant;
                  m_waits = 0;
                  m_phase = 2;
               end else begin
                  m_phase = 0;
               end
            default: if (bus.bus_ack_i) begin
                  m_phase = 0;
                  m_ptr   = (m_grant + 1) % D;
               end else begin
                  m_waits++;
                  if (T != 0 && m_waits == T) begin
                     m_phase = 0;
                     m_ptr   = (m_grant + 1) % D;
                     new_err = 1'b1;
                  end
               end
         endcase
         m_err = new_err;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int p0, v0, e0, n0;
   int exp_rr_id [5] = '{0, 1, 2, 3, 0};

   initial begin
      model_reset();
      rst_n          = 1'b0;
      bus.pndng_i    = 4'b1111;
      bus.dato_i     = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      bus.bus_ack_i  = 1'b0;

      // Reset held with everything pending.
      tick(3);
      @(negedge clk); #1;
      chk("lit_rst_pop",   bus.pop_o, 4'b0000);
      chk("lit_rst_valid", bus.bus_valid_o, 0);
      chk("lit_rst_busy",  bus.busy_o, 0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      @(negedge clk); #1;
      chk("lit_first_pop", bus.pop_o, 4'b0001);
      tick(1);
      bus.pndng_i   = 4'b0000;
      bus.bus_ack_i = 1'b1;
      tick(1);

      // Single source, immediate ack.
      p0 = dut_pops; v0 = dut_valid; n0 = deliv_id.size();
      bus.pndng_i = 4'b0100;
      bus.dato_i  = {16'h0000, 16'h0006, 16'h0000, 16'h0000};
      tick(2);
      bus.pndng_i = 4'b0000;
      tick(3);
      chk("lit_single_pops",  dut_pops - p0, 1);
      chk("lit_single_valid", dut_valid - v0, 1);
      chk("lit_single_n",     deliv_id.size() - n0, 1);
      if (deliv_id.size() == n0 + 1) begin
         chk("lit_single_id",  deliv_id[n0], 2);
         chk("lit_single_dat", deliv_dat[n0], 16'h0006);
      end

      // Round robin from a fresh pointer.
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      n0 = deliv_id.size(); p0 = dut_pops;
      bus.pndng_i = 4'b1111;
      bus.dato_i  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
      tick(15);
      bus.pndng_i = 4'b0000;
      tick(2);
      chk("lit_rr_n",    deliv_id.size() - n0, 5);
      chk("lit_rr_pops", dut_pops - p0, 5);
      if (deliv_id.size() >= n0 + 5)
         for (int k = 0; k < 5; k++) begin
            chk("lit_rr_id",  deliv_id[n0+k], exp_rr_id[k]);
            chk("lit_rr_dat", deliv_dat[n0+k], 16'h00A0 + exp_rr_id[k]);
         end

      // Back-pressure: five ack-less SEND cycles then ack.
      p0 = dut_pops; v0 = dut_valid; e0 = dut_errs; n0 = deliv_id.size();
      bus.bus_ack_i = 1'b0;
      bus.pndng_i   = 4'b0001;
      bus.dato_i    = {16'h0000, 16'h0000, 16'h0000, 16'h000A};
      tick(2);
      bus.pndng_i = 4'b0000;
      tick(5);
      bus.bus_ack_i = 1'b1;
      tick(1);
      bus.bus_ack_i = 1'b0;
      tick(2);
      chk("lit_bp_valid", dut_valid - v0, 6);
      chk("lit_bp_pops",  dut_pops - p0, 1);
      chk("lit_bp_err",   dut_errs - e0, 0);
      chk("lit_bp_n",     deliv_id.size() - n0, 1);
      if (deliv_id.size() == n0 + 1)
         chk("lit_bp_dat", deliv_dat[n0], 16'h000A);

      // Timeout on source 1, then source 3 is served next.
      p0 = dut_pops; v0 = dut_valid; e0 = dut_errs; n0 = deliv_id.size();
      bus.pndng_i = 4'b1010;
      bus.dato_i  = {16'h0033, 16'h0000, 16'h0011, 16'h0000};
      tick(2);
      bus.pndng_i = 4'b1000;
      tick(18);
      bus.pndng_i   = 4'b0000;
      bus.bus_ack_i = 1'b1;
      tick(1);
      bus.bus_ack_i = 1'b0;
      tick(2);
      chk("lit_to_err",   dut_errs - e0, 1);
      chk("lit_to_valid", dut_valid - v0, 17);
      chk("lit_to_pops",  dut_pops - p0, 2);
      chk("lit_to_n",     deliv_id.size() - n0, 1);
      if (deliv_id.size() == n0 + 1) begin
         chk("lit_to_id",  deliv_id[n0], 3);
         chk("lit_to_dat", deliv_dat[n0], 16'h0033);
      end

      // Pending flag drops before the pop, then a normal transfer.
      p0 = dut_pops; n0 = deliv_id.size();
      bus.pndng_i = 4'b0010;
      bus.dato_i  = {16'h0000, 16'h0000, 16'h000C, 16'h0000};
      tick(1);
      bus.pndng_i = 4'b0000;
      tick(3);
      chk("lit_drop_pops", dut_pops - p0, 0);
      chk("lit_drop_busy", bus.busy_o, 0);
      bus.pndng_i   = 4'b0010;
      bus.bus_ack_i = 1'b1;
      tick(2);
      bus.pndng_i = 4'b0000;
      tick(2);
      chk("lit_drop_pops2", dut_pops - p0, 1);
      chk("lit_drop_n",     deliv_id.size() - n0, 1);
      if (deliv_id.size() == n0 + 1)
         chk("lit_drop_id", deliv_id[n0], 1);

      // Reset in the middle of SEND.
      bus.bus_ack_i = 1'b0;
      bus.pndng_i   = 4'b0100;
      tick(2);
      bus.pndng_i = 4'b0000;
      tick(2);
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk("lit_mid_valid", bus.bus_valid_o, 0);
      chk("lit_mid_busy",  bus.busy_o, 0);
      chk("lit_mid_dato",  bus.bus_dato_o, 0);
      tick(1);
      rst_n       = 1'b1;
      bus.pndng_i = 4'b1111;
      tick(1);
      @(negedge clk); #1;
      chk("lit_mid_ptr0", bus.pop_o, 4'b0001);
      tick(1);
      bus.pndng_i   = 4'b0000;
      bus.bus_ack_i = 1'b1;
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
